euler_result_drain: RTL and testbench
=====================================

Name: euler_result_drain

Overview:
- Downstream stage of the Euler solver top.
- Once the solver has written its result vector into the result RAM, this block reads the words back sequentially and streams them out over a valid/ready interface.
- Adds a 2-entry output buffer so RAM read latency never stalls the stream or drops a word.
- Decouples the solver's single-cycle RAM writes from a host or next stage that may apply backpressure.

Parameters:
- ADD_SIZE, 16, result RAM address width.
- DATA_SIZE, 16, result word width.
- MAX_DIM, 6, maximum number of result words per drain; larger requests are clamped to this value.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start_drain  input  1  single-cycle pulse from the solver's finished indication.
- base_addr  input  ADD_SIZE  first result RAM address; sampled on an accepted start_drain.
- word_count  input  ADD_SIZE  number of words to drain; sampled on an accepted start_drain.
- rd_en  output  1  result RAM read strobe.
- rd_addr  output  ADD_SIZE  result RAM read address.
- rd_data  input  DATA_SIZE  RAM read data, valid exactly 1 cycle after rd_en.
- out_data  output  DATA_SIZE  streamed result word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- out_last  output  1  marks the final word of the drain.
- busy  output  1  high from an accepted start until the final word is accepted.
- done  output  1  one-cycle pulse after the final handshake, or after an empty request.

Behaviour:
- Reset (rst=0, async): state returns to IDLE; buffer is emptied; in-flight read is discarded. All outputs go to 0: rd_en, rd_addr, out_data, out_valid, out_last, busy, done.
- FSM states: IDLE, READ, FLUSH, FIN.
- IDLE:
  - start_drain=1 latches base_addr and n = min(word_count, MAX_DIM).
  - n=0 -> FIN; otherwise -> READ with busy=1 on the next cycle.
  - start_drain is ignored in every other state.
- READ: issues rd_en=1, rd_addr=base_addr+i only when (buffer occupancy + in-flight reads) < 2.
  - i increments per issued read; rd_addr wraps modulo 2^ADD_SIZE.
  - After n reads are issued -> FLUSH.
- Buffer capture: rd_data is written into the 2-entry FIFO on the cycle after each rd_en. The space check guarantees no overflow.
- Output side:
  - out_data and out_valid reflect the FIFO head.
  - Pop on out_valid && out_ready.
  - out_last=1 exactly when the head is word n-1.
  - out_valid may rise or fall only after a handshake or a fill. Once out_valid is asserted it holds, with out_data stable, until accepted.
- FLUSH: waits until the FIFO is empty and no read is in flight -> FIN.
- FIN: done=1 for one cycle, busy=0, then -> IDLE. A start_drain in this cycle is ignored.
- Throughput: 1 word/cycle with out_ready held high.
- Latency: first out_valid appears 3 cycles after the start_drain pulse (latch cycle, read issue, data capture).
- Simultaneous fill and pop in the same cycle: occupancy is unchanged and no word is lost.
- Reset mid-drain: the drain is abandoned with no done pulse; the next start_drain begins a fresh drain.

Optional Feature:
- Macro: DRAIN_CHECKSUM_EN.
- When defined:
  - Adds output port checksum (DATA_SIZE), which is the modulo-2^DATA_SIZE sum of all words accepted in the current drain.
  - It clears on an accepted start_drain, updates on each handshake, and holds its final value from the done pulse until the next start.
  - Reset value is 0.
- When undefined: the port and accumulator are absent; all other behaviour is identical.

Test Plan:
- RAM[10..13]={0x0001,0x0002,0x0003,0x0004}, base=10, count=4, out_ready=1 -> out_data 1,2,3,4 on consecutive cycles; first out_valid 3 cycles after start; out_last with 0x0004; done 1 cycle later.
- Same setup, out_ready toggling 1,0,0,1,... -> no word lost or duplicated; out_data stable while stalled; never more than 2 reads outstanding.
- count=0 -> done pulses 1 cycle after start; out_valid and rd_en never assert.
- count=9 with MAX_DIM=6 -> exactly 6 words; out_last on the 6th. base=0xFFFE -> reads 0xFFFE, 0xFFFF, 0x0000, ...
- rst=0 asserted after the 2nd word, then a new start with base=20, count=2 -> immediate all-zero outputs, no done pulse for the aborted drain, then a clean 2-word drain.
- DRAIN_CHECKSUM_EN, words {0xFFFF,0x0003} -> checksum=0x0002 at done; a second start_drain during busy is ignored.

Source files
------------

// File: rtl/euler_result_drain_if.sv
// rtl/euler_result_drain_if.sv - result word stream between the drain and its consumer
interface euler_result_drain_if #(
  parameter int DATA_SIZE = 16
) ();
  logic [DATA_SIZE-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/euler_result_drain.sv
// rtl/euler_result_drain.sv - reads the solver result RAM back and streams it out through a 2-entry buffer
// Optional running sum of accepted words on checksum_o when DRAIN_CHECKSUM_EN is defined.
module euler_result_drain #(
  parameter int ADD_SIZE  = 16,
  parameter int DATA_SIZE = 16,
  parameter int MAX_DIM   = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_drain_i,
  input  logic [ADD_SIZE-1:0]  base_addr_i,
  input  logic [ADD_SIZE-1:0]  word_count_i,
  output logic                 rd_en_o,
  output logic [ADD_SIZE-1:0]  rd_addr_o,
  input  logic [DATA_SIZE-1:0] rd_data_i,
  euler_result_drain_if.master out_if,
  output logic                 busy_o,
  output logic                 done_o
`ifdef DRAIN_CHECKSUM_EN
  ,
  output logic [DATA_SIZE-1:0] checksum_o
`endif
);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, FIN} state_e;

  localparam logic [ADD_SIZE-1:0] MAX_N = ADD_SIZE'(MAX_DIM);
  localparam logic [ADD_SIZE-1:0] ONE   = ADD_SIZE'(1);

  state_e               state_q;
  logic [ADD_SIZE-1:0]  base_q, n_q, issue_q, pop_idx_q;
  logic [DATA_SIZE-1:0] mem_q [2];
  logic                 wr_ptr_q, rd_ptr_q, pend_q;
  logic [1:0]           cnt_q;
  logic                 busy_q, done_q;

  logic                 pop;
  logic [1:0]           occ_d;
  logic                 rd_en;
  logic [ADD_SIZE-1:0]  n_req;

  // occ_d is the buffer occupancy after this cycle's capture and pop; a new read
  // may only be launched while it leaves a free slot for that read's data.
  assign pop     = out_if.out_valid && out_if.out_ready;
  assign occ_d   = cnt_q + {1'b0, pend_q} - {1'b0, pop};
  assign rd_en   = (state_q == READ) && (occ_d < 2'd2);
  assign n_req   = (word_count_i > MAX_N) ? MAX_N : word_count_i;

  assign rd_en_o   = rd_en;
  assign rd_addr_o = rd_en ? (base_q + issue_q) : '0;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

  assign out_if.out_valid = (cnt_q != 2'd0);
  assign out_if.out_data  = mem_q[rd_ptr_q];
  assign out_if.out_last  = out_if.out_valid && (pop_idx_q == n_q - ONE);

`ifdef DRAIN_CHECKSUM_EN
  logic [DATA_SIZE-1:0] sum_q;
  assign checksum_o = sum_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else if (state_q == IDLE && start_drain_i) begin
      sum_q <= '0;
    end else if (pop) begin
      sum_q <= sum_q + out_if.out_data;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      base_q    <= '0;
      n_q       <= '0;
      issue_q   <= '0;
      pop_idx_q <= '0;
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      pend_q    <= 1'b0;
      cnt_q     <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (pend_q) begin
        mem_q[wr_ptr_q] <= rd_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q  <= ~rd_ptr_q;
        pop_idx_q <= pop_idx_q + ONE;
      end
      cnt_q  <= occ_d;
      pend_q <= rd_en;
      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start_drain_i) begin
            base_q    <= base_addr_i;
            n_q       <= n_req;
            issue_q   <= '0;
            pop_idx_q <= '0;
            if (n_req == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= READ;
              busy_q  <= 1'b1;
            end
          end
        end
        READ: begin
          if (rd_en) begin
            issue_q <= issue_q + ONE;
            if (issue_q == n_q - ONE) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          // Leave as the final word is handed over so done follows it by one cycle.
          if (occ_d == 2'd0) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_euler_result_drain.sv
// tb/tb_euler_result_drain.sv - directed self-checking bench for euler_result_drain
module tb_euler_result_drain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base = '0;
  logic [15:0] wcnt = '0;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [15:0] rd_data;
  logic        busy, done;
`ifdef DRAIN_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  euler_result_drain_if #(.DATA_SIZE(16)) oif ();

  euler_result_drain #(.ADD_SIZE(16), .DATA_SIZE(16), .MAX_DIM(6)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_drain_i(start),
    .base_addr_i  (base),
    .word_count_i (wcnt),
    .rd_en_o      (rd_en),
    .rd_addr_o    (rd_addr),
    .rd_data_i    (rd_data),
    .out_if       (oif),
    .busy_o       (busy),
`ifdef DRAIN_CHECKSUM_EN
    .checksum_o   (checksum),
`endif
    .done_o       (done)
  );

  always #5 clk = ~clk;

  logic [15:0] ram [0:65535];
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] got_q[$];
  logic        got_last[$];
  logic [15:0] addr_q[$];
  int done_cnt, rd_cnt, valid_cnt, stab_err, issued, accepted, max_out;
  logic        prev_stall;
  logic [15:0] prev_data;

  always @(negedge clk) begin
    if (oif.out_valid && oif.out_ready) begin
      got_q.push_back(oif.out_data);
      got_last.push_back(oif.out_last);
      accepted++;
    end
    if (prev_stall && !(oif.out_valid && oif.out_data == prev_data)) stab_err++;
    prev_stall = oif.out_valid && !oif.out_ready;
    prev_data  = oif.out_data;
    if (rd_en) begin
      addr_q.push_back(rd_addr);
      rd_cnt++;
      issued++;
    end
    if (oif.out_valid) valid_cnt++;
    if (done) done_cnt++;
    if (issued - accepted > max_out) max_out = issued - accepted;
  end

  task automatic clear();
    got_q.delete();
    got_last.delete();
    addr_q.delete();
    done_cnt = 0; rd_cnt = 0; valid_cnt = 0; stab_err = 0;
    issued = 0; accepted = 0; max_out = 0; prev_stall = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input logic [15:0] b, input logic [15:0] c, input bit toggle);
    clear();
    base = b; wcnt = c; start = 1'b1; oif.out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 60 && done_cnt == 0; k++) begin
      oif.out_ready = toggle ? (k % 3 == 0) : 1'b1;
      tick();
    end
    check("drain_done_once", done_cnt, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check(tag, {rd_en, rd_addr, oif.out_data, oif.out_valid, oif.out_last, busy, done}, 32'h0);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) ram[a] = 16'(a) ^ 16'h5A00;
    ram[10] = 16'h0001; ram[11] = 16'h0002; ram[12] = 16'h0003; ram[13] = 16'h0004;
    ram[16'hFFFE] = 16'hA0A0; ram[16'hFFFF] = 16'hA1A1;
    ram[0] = 16'hA2A2; ram[1] = 16'hA3A3; ram[2] = 16'hA4A4; ram[3] = 16'hA5A5;
    ram[20] = 16'h1234; ram[21] = 16'h5678;
    ram[30] = 16'hFFFF; ram[31] = 16'h0003;
    oif.out_ready = 1'b0;
    clear();

    tick(); tick();
    check_zero_outputs("reset_outputs");
    rst_n = 1'b1;
    tick();

    // Basic 4-word drain, cycle-exact
    oif.out_ready = 1'b1;
    base = 16'd10; wcnt = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_first_read", {busy, rd_en, rd_addr}, {1'b1, 1'b1, 16'd10});
    check("t1_no_valid_c1", oif.out_valid, 1'b0);
    tick();
    check("t1_no_valid_c2", oif.out_valid, 1'b0);
    tick();
    check("t1_word0", {oif.out_valid, oif.out_last, oif.out_data}, {1'b1, 1'b0, 16'h0001});
    tick();
    check("t1_word1", {oif.out_valid, oif.out_last, oif.out_data}, {1'b1, 1'b0, 16'h0002});
    tick();
    check("t1_word2", {oif.out_valid, oif.out_last, oif.out_data}, {1'b1, 1'b0, 16'h0003});
    tick();
    check("t1_word3_last", {oif.out_valid, oif.out_last, oif.out_data, busy, done}, {1'b1, 1'b1, 16'h0004, 1'b1, 1'b0});
    tick();
    check("t1_done", {oif.out_valid, busy, done}, {1'b0, 1'b0, 1'b1});
    tick();
    check("t1_done_one_cycle", done, 1'b0);

    // Backpressure: ready pattern 1,0,0 repeating
    drain(16'd10, 16'd4, 1'b1);
    check("t2_word_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      check($sformatf("t2_word%0d", i), {got_last[i], got_q[i]}, {(i == 3), 16'(i + 1)});
    end
    check("t2_stable_while_stalled", stab_err, 0);
    check("t2_max_outstanding_le2", (max_out <= 2), 1'b1);

    // Empty request
    clear();
    base = 16'd5; wcnt = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_done_next_cycle", {done, busy}, {1'b1, 1'b0});
    tick();
    check("t3_done_drops", done, 1'b0);
    tick(); tick();
    check("t3_no_reads", rd_cnt, 0);
    check("t3_no_valid", valid_cnt, 0);

    // Clamp to MAX_DIM and address wrap
    drain(16'hFFFE, 16'd9, 1'b0);
    check("t4_word_count", got_q.size(), 6);
    check("t4_read_count", addr_q.size(), 6);
    for (int i = 0; i < 6 && i < got_q.size() && i < addr_q.size(); i++) begin
      check($sformatf("t4_addr%0d", i), addr_q[i], 16'(16'hFFFE + i));
      check($sformatf("t4_word%0d", i), {got_last[i], got_q[i]}, {(i == 5), 16'hA0A0 + 16'(i) * 16'h0101});
    end

    // Reset after the 2nd word, then a fresh drain
    clear();
    base = 16'd10; wcnt = 16'd4; start = 1'b1; oif.out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20 && got_q.size() < 2; k++) tick();
    check("t5_two_words_before_reset", got_q.size(), 2);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("t5_async_reset_outputs");
    tick(); tick(); tick();
    check_zero_outputs("t5_held_reset_outputs");
    rst_n = 1'b1;
    tick(); tick();
    check("t5_no_done_for_abort", done_cnt, 0);
    drain(16'd20, 16'd2, 1'b0);
    check("t5_word_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t5_word0", {got_last[0], got_q[0]}, {1'b0, 16'h1234});
      check("t5_word1", {got_last[1], got_q[1]}, {1'b1, 16'h5678});
    end

`ifdef DRAIN_CHECKSUM_EN
    clear();
    base = 16'd30; wcnt = 16'd2; start = 1'b1; oif.out_ready = 1'b1;
    tick();
    check("t6_checksum_cleared", checksum, 16'h0000);
    base = 16'd40; wcnt = 16'd3;
    tick();
    start = 1'b0;
    for (int k = 0; k < 30 && done_cnt == 0; k++) tick();
    check("t6_done_once", done_cnt, 1);
    check("t6_checksum", checksum, 16'h0002);
    tick(); tick(); tick();
    check("t6_second_start_ignored", {busy, 8'(rd_cnt), 8'(got_q.size())}, {1'b0, 8'd2, 8'd2});
    check("t6_checksum_holds", checksum, 16'h0002);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
